cmac_tx_axis_arbiter: RTL and testbench

- Packet-level arbiter that shares the single CMAC TX AXI4-Stream port (512-bit, txusrclk2 domain) between two requesters:
  - s0: ERNIC transmit stream.
  - s1: the axis packet generator / test stream.
- Sits between those sources and the CMAC tx_axis_* inputs.
- Grants whole packets only; a packet is never interleaved with the other source.
- Enforces a maximum packet length with abort-and-drain so a runaway source cannot lock the MAC.

---
 rtl/cmac_tx_axis_arbiter_if.sv | 15 +
 rtl/cmac_tx_axis_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cmac_tx_axis_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmac_tx_axis_arbiter_if.sv
// AXI4-Stream bundle for the CMAC TX arbiter: one instance per source and one toward the MAC.
interface cmac_tx_axis_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;

  modport master (output tvalid, tlast, tuser, tdata, tkeep, input tready);
  modport slave  (input tvalid, tlast, tuser, tdata, tkeep, output tready);
endinterface

// File: rtl/cmac_tx_axis_arbiter.sv
// Packet-level arbiter sharing the CMAC TX AXI4-Stream port between s0 (ERNIC) and s1 (test stream).
// Optional statistics counters are built when CMAC_TX_ARB_STATS_EN is defined.
module cmac_tx_axis_arbiter #(
  parameter int DATA_W        = 512,
  parameter int KEEP_W        = 64,
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_enable,
  cmac_tx_axis_arbiter_if.slave         s0_axis,
  cmac_tx_axis_arbiter_if.slave         s1_axis,
  cmac_tx_axis_arbiter_if.master        m_axis,
  output logic [1:0]                    grant,
  output logic                          busy,
  output logic                          bubble_err,
  output logic                          abort_pulse
`ifdef CMAC_TX_ARB_STATS_EN
  ,
  output logic [31:0]                   s0_pkt_cnt,
  output logic [31:0]                   s1_pkt_cnt,
  output logic [31:0]                   abort_cnt,
  output logic [31:0]                   bubble_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, PASS0, PASS1, DRAIN0, DRAIN1} state_t;

  localparam logic [15:0] LAST_BEAT = 16'(MAX_PKT_BEATS - 1);

  state_t      state, state_nxt;
  logic        last_winner, last_winner_nxt;
  logic [15:0] beat_cnt, beat_cnt_nxt;
  logic        in_bubble;

  logic              sel_s1, in_pass, in_drain;
  logic              sel_valid, sel_last, sel_user;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              m_hs, at_limit, pick_s1;

  logic              s0_tready, s1_tready;
  logic              m_tvalid, m_tlast, m_tuser;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;

  assign sel_s1   = (state == PASS1) || (state == DRAIN1);
  assign in_pass  = (state == PASS0) || (state == PASS1);
  assign in_drain = (state == DRAIN0) || (state == DRAIN1);

  assign sel_valid = sel_s1 ? s1_axis.tvalid : s0_axis.tvalid;
  assign sel_last  = sel_s1 ? s1_axis.tlast  : s0_axis.tlast;
  assign sel_user  = sel_s1 ? s1_axis.tuser  : s0_axis.tuser;
  assign sel_data  = sel_s1 ? s1_axis.tdata  : s0_axis.tdata;
  assign sel_keep  = sel_s1 ? s1_axis.tkeep  : s0_axis.tkeep;

  assign m_hs     = in_pass && sel_valid && m_axis.tready;
  // Truncation is flagged whenever the final allowed beat is offered, so tlast/tuser stay stable while tready is low.
  assign at_limit = (beat_cnt == LAST_BEAT) && !sel_last;
  assign pick_s1  = s1_axis.tvalid &&
                    (!s0_axis.tvalid || ((PRIORITY_MODE == 0) && !last_winner));

  assign s0_axis.tready = s0_tready;
  assign s1_axis.tready = s1_tready;
  assign m_axis.tvalid  = m_tvalid;
  assign m_axis.tlast   = m_tlast;
  assign m_axis.tuser   = m_tuser;
  assign m_axis.tdata   = m_tdata;
  assign m_axis.tkeep   = m_tkeep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      beat_cnt    <= '0;
      in_bubble   <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_winner <= last_winner_nxt;
      beat_cnt    <= beat_cnt_nxt;
      in_bubble   <= in_pass && !sel_valid;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_winner_nxt = last_winner;
    beat_cnt_nxt    = beat_cnt;
    case (state)
      IDLE: begin
        if (tx_enable && (s0_axis.tvalid || s1_axis.tvalid))
          state_nxt = pick_s1 ? PASS1 : PASS0;
      end
      PASS0, PASS1: begin
        if (m_hs) begin
          if (sel_last) begin
            state_nxt       = IDLE;
            last_winner_nxt = sel_s1;
            beat_cnt_nxt    = '0;
          end else if (at_limit) begin
            state_nxt    = sel_s1 ? DRAIN1 : DRAIN0;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 16'd1;
          end
        end
      end
      DRAIN0, DRAIN1: begin
        if (sel_valid && sel_last) begin
          state_nxt       = IDLE;
          last_winner_nxt = sel_s1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    m_tdata     = '0;
    m_tkeep     = '0;
    grant       = 2'b00;
    busy        = 1'b0;
    bubble_err  = 1'b0;
    abort_pulse = 1'b0;
    case (state)
      PASS0, PASS1: begin
        m_tvalid    = sel_valid;
        m_tdata     = sel_data;
        m_tkeep     = sel_keep;
        m_tlast     = sel_last | (sel_valid & at_limit);
        m_tuser     = sel_user | (sel_valid & at_limit);
        s0_tready   = !sel_s1 && m_axis.tready;
        s1_tready   = sel_s1 && m_axis.tready;
        grant       = sel_s1 ? 2'b10 : 2'b01;
        busy        = 1'b1;
        abort_pulse = m_hs && at_limit;
        bubble_err  = !sel_valid && (beat_cnt != '0) && !in_bubble;
      end
      DRAIN0, DRAIN1: begin
        s0_tready = !sel_s1;
        s1_tready = sel_s1;
        grant     = sel_s1 ? 2'b10 : 2'b01;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CMAC_TX_ARB_STATS_EN
  // Saturating event counters for ILA visibility; packets count only on a genuine tlast handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_pkt_cnt <= '0;
      s1_pkt_cnt <= '0;
      abort_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (m_hs && sel_last && !sel_s1 && (s0_pkt_cnt != '1)) s0_pkt_cnt <= s0_pkt_cnt + 32'd1;
      if (m_hs && sel_last && sel_s1 && (s1_pkt_cnt != '1))  s1_pkt_cnt <= s1_pkt_cnt + 32'd1;
      if (abort_pulse && (abort_cnt != '1))                  abort_cnt  <= abort_cnt + 32'd1;
      if (bubble_err && (bubble_cnt != '1))                  bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
// Directed bench for cmac_tx_axis_arbiter: one round-robin instance (long packets) and one fixed-priority instance with an 8-beat limit.
module tb_cmac_tx_axis_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic tx_enable;
  logic dut_sel;

  logic        s0_valid, s0_last, s1_valid, s1_last;
  logic [15:0] s0_tag, s1_tag;

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) a_s0 ();
  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) a_s1 ();
  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) a_m ();
  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) b_s0 ();
  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) b_s1 ();
  cmac_tx_axis_arbiter_if #(.DATA_W(512), .KEEP_W(64)) b_m ();

  assign a_s0.tvalid = s0_valid & !dut_sel;
  assign a_s0.tlast  = s0_last;
  assign a_s0.tuser  = 1'b0;
  assign a_s0.tdata  = {496'd0, s0_tag};
  assign a_s0.tkeep  = '1;
  assign a_s1.tvalid = s1_valid & !dut_sel;
  assign a_s1.tlast  = s1_last;
  assign a_s1.tuser  = 1'b0;
  assign a_s1.tdata  = {496'd0, s1_tag};
  assign a_s1.tkeep  = '1;
  assign a_m.tready  = 1'b1;

  assign b_s0.tvalid = s0_valid & dut_sel;
  assign b_s0.tlast  = s0_last;
  assign b_s0.tuser  = 1'b0;
  assign b_s0.tdata  = {496'd0, s0_tag};
  assign b_s0.tkeep  = '1;
  assign b_s1.tvalid = s1_valid & dut_sel;
  assign b_s1.tlast  = s1_last;
  assign b_s1.tuser  = 1'b0;
  assign b_s1.tdata  = {496'd0, s1_tag};
  assign b_s1.tkeep  = '1;
  assign b_m.tready  = 1'b1;

  logic [1:0] a_grant, b_grant;
  logic       a_busy, b_busy, a_bubble, b_bubble, a_abort, b_abort;

`ifdef CMAC_TX_ARB_STATS_EN
  logic [31:0] a_s0c, a_s1c, a_abc, a_buc, b_s0c, b_s1c, b_abc, b_buc;
`endif

  cmac_tx_axis_arbiter #(.DATA_W(512), .KEEP_W(64), .PRIORITY_MODE(0), .MAX_PKT_BEATS(256)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .tx_enable   (tx_enable),
    .s0_axis     (a_s0),
    .s1_axis     (a_s1),
    .m_axis      (a_m),
    .grant       (a_grant),
    .busy        (a_busy),
    .bubble_err  (a_bubble),
    .abort_pulse (a_abort)
`ifdef CMAC_TX_ARB_STATS_EN
    ,
    .s0_pkt_cnt  (a_s0c),
    .s1_pkt_cnt  (a_s1c),
    .abort_cnt   (a_abc),
    .bubble_cnt  (a_buc)
`endif
  );

  cmac_tx_axis_arbiter #(.DATA_W(512), .KEEP_W(64), .PRIORITY_MODE(1), .MAX_PKT_BEATS(8)) u_fp (
    .clk         (clk),
    .reset       (reset),
    .tx_enable   (tx_enable),
    .s0_axis     (b_s0),
    .s1_axis     (b_s1),
    .m_axis      (b_m),
    .grant       (b_grant),
    .busy        (b_busy),
    .bubble_err  (b_bubble),
    .abort_pulse (b_abort)
`ifdef CMAC_TX_ARB_STATS_EN
    ,
    .s0_pkt_cnt  (b_s0c),
    .s1_pkt_cnt  (b_s1c),
    .abort_cnt   (b_abc),
    .bubble_cnt  (b_buc)
`endif
  );

  logic [1:0]   grant;
  logic         busy, bubble_err, abort_pulse;
  logic         m_valid, m_last, m_user, s0_ready, s1_ready;
  logic [511:0] m_data;

  assign grant       = dut_sel ? b_grant    : a_grant;
  assign busy        = dut_sel ? b_busy     : a_busy;
  assign bubble_err  = dut_sel ? b_bubble   : a_bubble;
  assign abort_pulse = dut_sel ? b_abort    : a_abort;
  assign m_valid     = dut_sel ? b_m.tvalid : a_m.tvalid;
  assign m_last      = dut_sel ? b_m.tlast  : a_m.tlast;
  assign m_user      = dut_sel ? b_m.tuser  : a_m.tuser;
  assign m_data      = dut_sel ? b_m.tdata  : a_m.tdata;
  assign s0_ready    = dut_sel ? b_s0.tready : a_s0.tready;
  assign s1_ready    = dut_sel ? b_s1.tready : a_s1.tready;

  task automatic applyStimulus(input logic v0, input logic l0, input logic [15:0] t0,
                               input logic v1, input logic l1, input logic [15:0] t1);
    s0_valid = v0;
    s0_last  = l0;
    s0_tag   = t0;
    s1_valid = v1;
    s1_last  = l1;
    s1_tag   = t1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int c0, c1, w;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    dut_sel   = 1'b0;
    reset     = 1'b1;
    tx_enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_grant",  512'(grant), 512'(2'b00));
    checkOutput("rst_busy",   512'(busy), 512'(1'b0));
    checkOutput("rst_bubble", 512'(bubble_err), 512'(1'b0));
    checkOutput("rst_abort",  512'(abort_pulse), 512'(1'b0));
    checkOutput("rst_mvalid", 512'(m_valid), 512'(1'b0));
    tick();
    reset     = 1'b0;
    tx_enable = 1'b1;

    $display("[TB] single s0 packet of 9 beats");
    applyStimulus(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t1_arb_grant", 512'(grant), 512'(2'b00));
    checkOutput("t1_arb_ready", 512'(s0_ready), 512'(1'b0));
    checkOutput("t1_arb_mvalid", 512'(m_valid), 512'(1'b0));
    for (int i = 1; i <= 9; i++) begin
      tick();
      applyStimulus(1'b1, (i == 9), 16'(i), 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      checkOutput("t1_grant",  512'(grant), 512'(2'b01));
      checkOutput("t1_busy",   512'(busy), 512'(1'b1));
      checkOutput("t1_mvalid", 512'(m_valid), 512'(1'b1));
      checkOutput("t1_data",   m_data, 512'(16'(i)));
      checkOutput("t1_last",   512'(m_last), 512'(i == 9));
      checkOutput("t1_user",   512'(m_user), 512'(1'b0));
      checkOutput("t1_ready",  512'(s0_ready), 512'(1'b1));
    end
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t1_end_grant", 512'(grant), 512'(2'b00));
    checkOutput("t1_end_busy",  512'(busy), 512'(1'b0));
    checkOutput("t1_end_mvalid", 512'(m_valid), 512'(1'b0));

    $display("[TB] round-robin with both sources saturated");
    do_reset();
    c0 = 0;
    c1 = 0;
    for (int pkt = 0; pkt < 4; pkt++) begin
      w = pkt % 2;
      applyStimulus(1'b1, (c0 % 4 == 3), 16'(c0), 1'b1, (c1 % 4 == 3), 16'h1000 + 16'(c1));
      @(negedge clk);
      checkOutput("t2_gap_grant",  512'(grant), 512'(2'b00));
      checkOutput("t2_gap_mvalid", 512'(m_valid), 512'(1'b0));
      tick();
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'b1, (c0 % 4 == 3), 16'(c0), 1'b1, (c1 % 4 == 3), 16'h1000 + 16'(c1));
        @(negedge clk);
        checkOutput("t2_grant", 512'(grant), (w == 1) ? 512'(2'b10) : 512'(2'b01));
        checkOutput("t2_data",  m_data, (w == 1) ? 512'(16'h1000 + 16'(c1)) : 512'(16'(c0)));
        checkOutput("t2_last",  512'(m_last), 512'(k == 3));
        checkOutput("t2_other_ready", (w == 1) ? 512'(s0_ready) : 512'(s1_ready), 512'(1'b0));
        tick();
        if (w == 1) c1++;
        else        c0++;
      end
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    $display("[TB] fixed priority with both sources saturated");
    dut_sel = 1'b1;
    do_reset();
    c0 = 0;
    c1 = 0;
    for (int pkt = 0; pkt < 3; pkt++) begin
      applyStimulus(1'b1, (c0 % 4 == 3), 16'(c0), 1'b1, (c1 % 4 == 3), 16'h1000 + 16'(c1));
      @(negedge clk);
      checkOutput("t3_gap_grant", 512'(grant), 512'(2'b00));
      checkOutput("t3_gap_s1_ready", 512'(s1_ready), 512'(1'b0));
      tick();
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'b1, (c0 % 4 == 3), 16'(c0), 1'b1, (c1 % 4 == 3), 16'h1000 + 16'(c1));
        @(negedge clk);
        checkOutput("t3_grant",    512'(grant), 512'(2'b01));
        checkOutput("t3_data",     m_data, 512'(16'(c0)));
        checkOutput("t3_last",     512'(m_last), 512'(k == 3));
        checkOutput("t3_s1_ready", 512'(s1_ready), 512'(1'b0));
        checkOutput("t3_abort",    512'(abort_pulse), 512'(1'b0));
        tick();
        c0++;
      end
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    $display("[TB] s1 runaway packet truncated at 8 beats");
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h1001);
    @(negedge clk);
    checkOutput("t4_arb_grant", 512'(grant), 512'(2'b00));
    tick();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h1000 + 16'(k));
      @(negedge clk);
      checkOutput("t4_grant",  512'(grant), 512'(2'b10));
      checkOutput("t4_mvalid", 512'(m_valid), 512'(1'b1));
      checkOutput("t4_data",   m_data, 512'(16'h1000 + 16'(k)));
      checkOutput("t4_last",   512'(m_last), 512'(k == 8));
      checkOutput("t4_user",   512'(m_user), 512'(k == 8));
      checkOutput("t4_abort",  512'(abort_pulse), 512'(k == 8));
      checkOutput("t4_ready",  512'(s1_ready), 512'(1'b1));
      tick();
    end
    for (int k = 9; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, (k == 12), 16'h1000 + 16'(k));
      @(negedge clk);
      checkOutput("t4_drain_mvalid", 512'(m_valid), 512'(1'b0));
      checkOutput("t4_drain_ready",  512'(s1_ready), 512'(1'b1));
      checkOutput("t4_drain_abort",  512'(abort_pulse), 512'(1'b0));
      checkOutput("t4_drain_busy",   512'(busy), 512'(1'b1));
      checkOutput("t4_drain_grant",  512'(grant), 512'(2'b10));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t4_end_grant", 512'(grant), 512'(2'b00));
    checkOutput("t4_end_busy",  512'(busy), 512'(1'b0));

    $display("[TB] s0 bubble of 3 cycles inside a 6-beat packet");
    dut_sel = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t5_arb_grant", 512'(grant), 512'(2'b00));
    tick();
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(1'b1, 1'b0, 16'(k), 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      checkOutput("t5_data",   m_data, 512'(16'(k)));
      checkOutput("t5_bubble", 512'(bubble_err), 512'(1'b0));
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      checkOutput("t5_gap_bubble", 512'(bubble_err), 512'(j == 0));
      checkOutput("t5_gap_mvalid", 512'(m_valid), 512'(1'b0));
      checkOutput("t5_gap_grant",  512'(grant), 512'(2'b01));
      tick();
    end
    for (int k = 3; k <= 6; k++) begin
      applyStimulus(1'b1, (k == 6), 16'(k), 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      checkOutput("t5_data",   m_data, 512'(16'(k)));
      checkOutput("t5_last",   512'(m_last), 512'(k == 6));
      checkOutput("t5_bubble", 512'(bubble_err), 512'(1'b0));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t5_end_grant", 512'(grant), 512'(2'b00));

    $display("[TB] tx_enable gating and asynchronous reset mid-packet");
    tick();
    tx_enable = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 16'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("t6_dis_grant", 512'(grant), 512'(2'b00));
      checkOutput("t6_dis_ready", 512'(s0_ready), 512'(1'b0));
      tick();
    end
    tx_enable = 1'b1;
    @(negedge clk);
    checkOutput("t6_en_grant_same", 512'(grant), 512'(2'b00));
    tick();
    @(negedge clk);
    checkOutput("t6_en_grant", 512'(grant), 512'(2'b01));
    checkOutput("t6_data1",    m_data, 512'(16'h0001));
    tick();
    tx_enable = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("t6_cont_grant",  512'(grant), 512'(2'b01));
    checkOutput("t6_cont_mvalid", 512'(m_valid), 512'(1'b1));
    checkOutput("t6_data2",       m_data, 512'(16'h0002));
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_mvalid", 512'(m_valid), 512'(1'b0));
    checkOutput("t6_rst_grant",  512'(grant), 512'(2'b00));
    checkOutput("t6_rst_busy",   512'(busy), 512'(1'b0));
    checkOutput("t6_rst_ready",  512'(s0_ready), 512'(1'b0));
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
